// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start/stop validation and a one-entry valid/ack output register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic [DIV_WIDTH-1:0]      div,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ack,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int unsigned BitIdxW = $clog2(UART_DATA_BITS);
  localparam logic [BitIdxW-1:0] LastIdx = BitIdxW'(UART_DATA_BITS - 1);
  localparam logic [BitIdxW-1:0] IdxOne = BitIdxW'(1);
  localparam logic [DIV_WIDTH:0] TimerOne = (DIV_WIDTH + 1)'(1);

  logic rx_s;

  uart_rx_state_e state_q, state_d;
  // One extra MSB: it sets only when the counter underflows past zero, which is the tick.
  logic [DIV_WIDTH:0]          timer_q, timer_d;
  logic [DIV_WIDTH-1:0]        div_q, div_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]   data_q, data_d;
  logic [BitIdxW-1:0]          idx_q, idx_d;
  logic                        valid_q, valid_d;
  logic                        frame_err_q, frame_err_d;
  logic                        overrun_q, overrun_d;
  logic                        tick;
  logic                        deliver;

  sync_2ff #(
    .ResetValue (UART_IDLE_LEVEL)
  ) u_rx_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  assign tick = timer_q[DIV_WIDTH];

  // Frame FSM, bit timer and output handshake next-state logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q - TimerOne;
    div_d       = div_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    case (state_q)
      StIdle: begin
        timer_d = timer_q;
        if (rx_s != UART_IDLE_LEVEL) begin
          state_d = StStart;
          div_d   = div;
          // Half a period so the first tick lands mid start bit.
          timer_d = {2'b00, div[DIV_WIDTH-1:1]};
        end
      end
      StStart: begin
        if (tick) begin
          timer_d = {1'b0, div_q};
          if (rx_s == UART_IDLE_LEVEL) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          timer_d = {1'b0, div_q};
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IdxOne;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          timer_d = {1'b0, div_q};
          if (rx_s == UART_IDLE_LEVEL) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        timer_d = timer_q;
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (valid_q && ack) begin
      valid_d = 1'b0;
    end
    // A byte landing in the same cycle as a consume replaces the old one without overrun.
    if (deliver) begin
      if (!valid_q || ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      div_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected bytes and checks, a monitor compares.
module tb_uart_rx;

  localparam int unsigned BitCycles = 16;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] div;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  logic [7:0] exp_q[$];
  chk_t       chk_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int fe_rise  = 0;
  int fe_cyc   = 0;
  int ov_rise  = 0;
  int ov_cyc   = 0;
  int fe_rise_base, fe_cyc_base, ov_rise_base, ov_cyc_base;

  uart_rx #(
    .DIV_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .div       (div),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after each rising edge; sole owner of the counters.
  initial begin
    logic prev_valid = 1'b0;
    logic prev_fe    = 1'b0;
    logic prev_ov    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      // A new byte is presented if valid rose, or stayed high across a consume.
      if (valid && (!prev_valid || ack)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h, want no byte", data);
        end else begin
          compare("byte", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) fe_cyc++;
      if (frame_err && !prev_fe) fe_rise++;
      if (overrun) ov_cyc++;
      if (overrun && !prev_ov) ov_rise++;
      while (chk_q.size() > 0) begin
        chk_t c;
        c = chk_q.pop_front();
        compare(c.name, c.act, c.exp);
      end
      prev_valid = valid;
      prev_fe    = frame_err;
      prev_ov    = overrun;
    end
  end

  task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cycles(BitCycles);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BitCycles);
    end
    rx = stop;
    wait_cycles(BitCycles);
  endtask

  task automatic rebase();
    fe_rise_base = fe_rise;
    fe_cyc_base  = fe_cyc;
    ov_rise_base = ov_rise;
    ov_cyc_base  = ov_cyc;
  endtask

  task automatic end_check(input string tag, input int exp_fe, input int exp_ov);
    push_chk({tag, "_pending_bytes"}, 32'(exp_q.size()), 32'd0);
    push_chk({tag, "_frame_err_pulses"}, 32'(fe_rise - fe_rise_base), 32'(exp_fe));
    push_chk({tag, "_frame_err_cycles"}, 32'(fe_cyc - fe_cyc_base), 32'(exp_fe));
    push_chk({tag, "_overrun_pulses"}, 32'(ov_rise - ov_rise_base), 32'(exp_ov));
    push_chk({tag, "_overrun_cycles"}, 32'(ov_cyc - ov_cyc_base), 32'(exp_ov));
    wait_cycles(2);
    rebase();
  endtask

  initial begin
    int viol;
    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    div   = 8'd14;
    rebase();
    wait_cycles(3);
    push_chk("rst_data", 32'(data), 32'd0);
    push_chk("rst_valid", 32'(valid), 32'd0);
    push_chk("rst_busy", 32'(busy), 32'd0);
    push_chk("rst_frame_err", 32'(frame_err), 32'd0);
    push_chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Two bytes, consumer always ready.
    ack = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_frame(8'h55, 1'b1);
    send_frame(8'hA3, 1'b1);
    wait_cycles(20);
    end_check("ack_high", 0, 0);

    // Byte held until acknowledged.
    ack = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_cycles(4);
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      if (!(valid === 1'b1 && data === 8'h3C)) viol++;
      wait_cycles(1);
    end
    push_chk("hold_violations", 32'(viol), 32'd0);
    ack = 1'b1;
    wait_cycles(1);
    ack = 1'b0;
    push_chk("valid_clear", 32'(valid), 32'd0);
    end_check("hold", 0, 0);

    // Back-to-back bytes with no consume: second one overruns.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(20);
    push_chk("overrun_data_kept", 32'(data), 32'h11);
    end_check("overrun", 0, 1);
    ack = 1'b1;
    wait_cycles(1);
    ack = 1'b0;
    wait_cycles(4);

    // Short low glitch on idle line, then a normal byte.
    ack = 1'b1;
    rx  = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(40);
    push_chk("glitch_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_cycles(20);
    end_check("glitch", 0, 0);

    // Bad stop bit with line held low, then recovery.
    send_frame(8'h81, 1'b0);
    wait_cycles(100);
    push_chk("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cycles(20);
    push_chk("break_exit_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_cycles(20);
    end_check("break", 1, 0);

    // Reset in the middle of a frame while a byte is pending.
    ack = 1'b0;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1);
    wait_cycles(10);
    push_chk("pre_reset_valid", 32'(valid), 32'd1);
    rx = 1'b0;
    wait_cycles(BitCycles);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_cycles(BitCycles);
    end
    rx = 1'b0;
    wait_cycles(BitCycles / 2);
    rst_n = 1'b0;
    #1;
    push_chk("midrst_data", 32'(data), 32'd0);
    push_chk("midrst_valid", 32'(valid), 32'd0);
    push_chk("midrst_busy", 32'(busy), 32'd0);
    push_chk("midrst_frame_err", 32'(frame_err), 32'd0);
    push_chk("midrst_overrun", 32'(overrun), 32'd0);
    rx = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(5);
    ack = 1'b1;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    wait_cycles(20);
    end_check("midrst", 0, 0);

    wait_cycles(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-direction counterpart of the team's uart_tx core, using the same divider convention and a valid/ack handshake.
- Lets board-bring-up designs (pin scan, loopback, command consoles) take bytes from a host over a single pad.
- Oversamples the synchronised line and validates start and stop bits.
- Presents each byte on a one-entry output register until the consumer acknowledges it.

Parameters:
- DIV_WIDTH, 8: width of the div input and of the internal bit-timer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx  in  1  serial line; asynchronous to clk; idles high.
- div  in  DIV_WIDTH  bit period = div+2 clk cycles (same convention as uart_tx); sampled when a start edge is accepted, held constant per frame.
- data  out  8  received byte; LSB received first.
- valid  out  1  data holds an unconsumed byte.
- ack  in  1  consumer takes data; only meaningful while valid=1.
- busy  out  1  a frame is in progress (any state other than IDLE).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the previous one was still unacknowledged.

Behaviour:
- Reset values: data=0, valid=0, busy=0, frame_err=0, overrun=0; state=IDLE; synchroniser flops=1 (line idle).
- Input sync: 2-FF synchroniser on rx giving rx_s. All decisions use rx_s. 2-cycle input latency.
- Bit timer: down-counter loaded with div, ticks when it underflows past zero, reloads on tick. A tick occurs every div+2 cycles.
- State IDLE:
  - rx_s==0 → START; timer loaded with div>>1, so the first tick falls mid start bit.
  - Otherwise stay in IDLE.
- State START, on tick:
  - rx_s==1 (glitch) → IDLE, no output, no error.
  - rx_s==0 → DATA; bit index=0; timer reloaded with div.
- State DATA, on tick:
  - Shift rx_s into the shift register MSB (LSB-first reception); increment bit index.
  - After the 8th sample → STOP.
- State STOP, on tick:
  - rx_s==1 → deliver the byte (see handshake); go to IDLE.
  - rx_s==0 → frame_err pulses for 1 cycle; byte discarded; go to BREAK.
- State BREAK: wait until rx_s==1, then IDLE. This prevents a held-low line from re-triggering.
- Output handshake:
  - Delivery at the stop-sample edge; valid=1 and data visible from the following cycle.
  - valid stays high and data stays stable until a cycle with valid&ack; valid clears on the next edge.
  - Delivery while valid=1 and ack=0 that cycle: overrun pulses for 1 cycle, the old data is kept, the new byte is dropped.
  - Delivery in the same cycle as valid&ack: the new byte is loaded, valid stays 1, no overrun.
  - ack while valid=0 is ignored.
- Reception continues while valid=1; the receiver never stalls the line.
- Reset mid-frame: immediate return to IDLE, all outputs to their reset values, the partial byte is lost.
- div changes mid-frame: not supported; the behaviour is undefined until the next IDLE.

Decomposition:
- Shared uart package, also usable by uart_tx: frame constants (UART_DATA_BITS=8, idle level 1) and the state encoding localparams (IDLE, START, DATA, STOP, BREAK).
- One natural sub-module: sync_2ff (parameterised reset value), reused for other asynchronous pad inputs.
- The bit timer stays inline.

Test Plan:
- div=14 (16-cycle bits), send 0x55 then 0xA3 with ack held high → valid pulses twice; data 0x55 then 0xA3; frame_err=0, overrun=0.
- div=14, send 0x3C, ack=0 for 200 cycles → valid stays 1 and data stays 0x3C throughout; one ack cycle → valid=0 on the next cycle.
- div=14, send 0x11 and 0x22 back-to-back, ack=0 → overrun pulses exactly once, 1 cycle after the second stop sample; data stays 0x11.
- div=14, 4-cycle low glitch on idle rx → no valid, no frame_err; then 0x7E arrives normally and is received correctly.
- div=14, frame 0x81 with the stop bit driven low and rx held low for 100 cycles → frame_err pulses once, no valid, no re-trigger until rx returns high; then 0x42 is received correctly.
- div=14, deassert rst_n during bit 4 of a frame → outputs return to their reset values immediately, busy=0; the next frame 0x99 after release is received correctly.
